// File: rtl/mode_counter_pkg.sv
// Shared types and constants for the mode_counter timebase.
// Optional prescaler is enabled with `define MODE_COUNTER_PRESCALE_EN.
package mode_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/mode_counter_en_prescaler.sv
// Enable prescaler: passes every PRESCALE-th qualified enable as a single tick.
// Only instantiated by mode_counter when MODE_COUNTER_PRESCALE_EN is defined.
module en_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_clr,
    input  logic en_in,
    output logic tick_out
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick_out = en_in && !sync_clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en_in) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Parametrised up/down counter with free-run/one-shot FSM, tc and compare match.
// Define MODE_COUNTER_PRESCALE_EN to add the PRESCALE parameter and pre_tick output.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
`ifdef MODE_COUNTER_PRESCALE_EN
  , parameter int unsigned PRESCALE  = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_match,
    output logic             busy,
    output logic             done
`ifdef MODE_COUNTER_PRESCALE_EN
  , output logic             pre_tick
`endif
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_COUNT);

    state_t           state;
    logic             mode_q;
    logic             step;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] term_val;
    logic             wrap;
    logic             hit_term;

`ifdef MODE_COUNTER_PRESCALE_EN
    logic tick;

    en_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .sync_clr (clr | stop | start | load),
        .en_in    (en && (state == RUN)),
        .tick_out (tick)
    );

    assign pre_tick = tick;
    assign step     = tick;
`else
    assign step = en && (state == RUN);
`endif

    assign cmp_match = (count == cmp_val);

    always_comb begin
        start_val    = (dir == DIR_DOWN) ? TOP : '0;
        load_clamped = (load_val > TOP) ? TOP : load_val;
        if (dir == DIR_UP) begin
            wrap     = (count == TOP);
            next_val = wrap ? '0 : count + 1'b1;
            term_val = TOP;
        end else begin
            wrap     = (count == '0);
            next_val = wrap ? TOP : count - 1'b1;
            term_val = '0;
        end
        // One-shot also stops if already parked on the terminal value, so it never wraps
        hit_term = (count == term_val) || (next_val == term_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            state  <= IDLE;
            mode_q <= MODE_FREE;
            tc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clr) begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                count  <= start_val;
                state  <= RUN;
                mode_q <= oneshot;
                busy   <= 1'b1;
                done   <= 1'b0;
            end else if (load) begin
                count <= load_clamped;
            end else if (step) begin
                if ((mode_q == MODE_ONESHOT) && hit_term) begin
                    count <= term_val;
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    tc    <= 1'b1;
                end else begin
                    count <= next_val;
                    tc    <= wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Directed self-checking bench for mode_counter (MAX 255, 9 and 5 instances).
// Also covers pre_tick when built with MODE_COUNTER_PRESCALE_EN.
module tb_mode_counter;

`ifdef MODE_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1;
    logic       oneshot = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] load_val = '0, cmp_val = '0;

    logic [7:0] count_a, count_b, count_c;
    logic       tc_a, tc_b, tc_c;
    logic       cm_a, cm_b, cm_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
`ifdef MODE_COUNTER_PRESCALE_EN
    logic       pt_a, pt_b, pt_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(8), .MAX_COUNT(255)) u255 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .start(start), .stop(stop), .cmp_val(cmp_val),
        .count(count_a), .tc(tc_a), .cmp_match(cm_a), .busy(busy_a), .done(done_a)
`ifdef MODE_COUNTER_PRESCALE_EN
      , .pre_tick(pt_a)
`endif
    );

    mode_counter #(.WIDTH(8), .MAX_COUNT(9)) u9 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .start(start), .stop(stop), .cmp_val(cmp_val),
        .count(count_b), .tc(tc_b), .cmp_match(cm_b), .busy(busy_b), .done(done_b)
`ifdef MODE_COUNTER_PRESCALE_EN
      , .pre_tick(pt_b)
`endif
    );

    mode_counter #(.WIDTH(8), .MAX_COUNT(5)) u5 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .start(start), .stop(stop), .cmp_val(cmp_val),
        .count(count_c), .tc(tc_c), .cmp_match(cm_c), .busy(busy_c), .done(done_c)
`ifdef MODE_COUNTER_PRESCALE_EN
      , .pre_tick(pt_c)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_count", {24'd0, count_a}, 0);
        chk("rst_tc", {31'd0, tc_a}, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_done", {31'd0, done_a}, 0);
        rst = 1'b0;
        tick();

        // MAX=255 free-run up: full lap with a single tc at the wrap
        dir = 1'b1; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("fr_up_start", {24'd0, count_a}, 0);
        chk("fr_up_busy0", {31'd0, busy_a}, 1);
        en = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            repeat (PS) tick();
            chk("fr_up_count", {24'd0, count_a}, k % 256);
            chk("fr_up_tc", {31'd0, tc_a}, (k == 256) ? 1 : 0);
        end
        chk("fr_up_busy1", {31'd0, busy_a}, 1);
        en = 1'b0;

        // MAX=9 free-run down
        dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("fr_dn_start", {24'd0, count_b}, 9);
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            repeat (PS) tick();
            chk("fr_dn_count", {24'd0, count_b}, (k <= 9) ? 9 - k : 9);
            chk("fr_dn_tc", {31'd0, tc_b}, (k == 10) ? 1 : 0);
        end
        en = 1'b0;
        cmp_val = 8'd9;
        #1;
        chk("cmp_hit", {31'd0, cm_b}, 1);
        cmp_val = 8'd3;
        #1;
        chk("cmp_miss", {31'd0, cm_b}, 0);

        // MAX=5 one-shot up
        dir = 1'b1; oneshot = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("os_start", {24'd0, count_c}, 0);
        chk("os_busy", {31'd0, busy_c}, 1);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            repeat (PS) tick();
            chk("os_count", {24'd0, count_c}, k);
            chk("os_tc", {31'd0, tc_c}, (k == 5) ? 1 : 0);
            chk("os_done", {31'd0, done_c}, (k == 5) ? 1 : 0);
            chk("os_busy_run", {31'd0, busy_c}, (k == 5) ? 0 : 1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("os_hold", {24'd0, count_c}, 5);
            chk("os_hold_tc", {31'd0, tc_c}, 0);
            chk("os_hold_done", {31'd0, done_c}, 1);
        end
        en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("os_restart", {24'd0, count_c}, 0);
        chk("os_restart_busy", {31'd0, busy_c}, 1);
        chk("os_restart_done", {31'd0, done_c}, 0);

        // MAX=9 load clamp, then clr beats load and en
        oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; load = 1'b1; load_val = 8'd12;
        tick();
        chk("load_clamp9", {24'd0, count_b}, 9);
        chk("load_clamp5", {24'd0, count_c}, 5);
        chk("load_busy", {31'd0, busy_b}, 1);
        chk("load_tc", {31'd0, tc_b}, 0);
        clr = 1'b1; en = 1'b1;
        tick();
        chk("clr_count", {24'd0, count_b}, 0);
        chk("clr_busy", {31'd0, busy_b}, 0);
        chk("clr_tc", {31'd0, tc_b}, 0);
        clr = 1'b0; load = 1'b0;
        repeat (PS) tick();
        chk("idle_hold", {24'd0, count_b}, 0);
        en = 1'b0;

        // Async reset mid-run at 37
        dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        repeat (37 * PS) tick();
        chk("pre_rst_count", {24'd0, count_a}, 37);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", {24'd0, count_a}, 0);
        chk("async_rst_busy", {31'd0, busy_a}, 0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_count", {24'd0, count_a}, 0);

        // Stop at 20 holds count
        start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        repeat (20 * PS) tick();
        chk("pre_stop", {24'd0, count_a}, 20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_count", {24'd0, count_a}, 20);
        chk("stop_busy", {31'd0, busy_a}, 0);
        chk("stop_tc", {31'd0, tc_a}, 0);
        repeat (PS) tick();
        chk("stop_hold", {24'd0, count_a}, 20);
        en = 1'b0;

`ifdef MODE_COUNTER_PRESCALE_EN
        // Prescaler: 12 en cycles give 3 steps
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            en = 1'b1;
            #1;
            chk("pre_tick", {31'd0, pt_a}, (i % 4 == 0) ? 1 : 0);
            tick();
        end
        en = 1'b0;
        chk("pre_count", {24'd0, count_a}, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
